// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the access unit (master) and memory (slave).
// Request fields are valid while req is high; rdata is valid with ack.
interface dmem_access_unit_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  wea;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req, we, addr, wea, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wea, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/dmem_access_unit.sv
// Load/store bus master for the MEM stage: issues one bus transfer per
// access, stalls the pipeline until ack, and reports misalign/timeout faults.
module dmem_access_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter int unsigned CNT_W          = 7,
   parameter logic [1:0]  DM_BYTE        = 2'b00,
   parameter logic [1:0]  DM_HALFWORD    = 2'b01,
   parameter logic [1:0]  DM_WORD        = 2'b10
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        acc_valid,
   input  logic        acc_we,
   input  logic [1:0]  acc_width,
   input  logic [31:0] acc_addr,
   input  logic [31:0] acc_wdata,
   input  logic        flush,
   dmem_access_unit_if.master bus,
   output logic [31:0] Data_in,
   output logic        mem_stall,
   output logic        acc_err,
   output logic [1:0]  err_cause
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic             squash;
   logic             is_byte;
   logic             is_half;
   logic             misal;
   logic [3:0]       mask;
   logic [3:0]       wea_c;
   logic [31:0]      wdata_c;
   logic             start;
   logic             timeout;
   logic             finish;
   logic             squash_c;

   // Any width code other than byte/halfword is handled as a word.
   assign is_byte = (acc_width == DM_BYTE);
   assign is_half = (acc_width == DM_HALFWORD);
   assign misal   = (is_half & acc_addr[0]) |
                    (~is_byte & ~is_half & (acc_addr[1:0] != 2'b00));

   always_comb begin
      mask = 4'b1111;
      unique case (1'b1)
         is_byte: mask = 4'b0001 << acc_addr[1:0];
         is_half: mask = 4'b0011 << acc_addr[1:0];
         default: mask = 4'b1111;
      endcase
   end

   assign wea_c    = acc_we ? mask : 4'b0000;
   assign wdata_c  = acc_wdata << {acc_addr[1:0], 3'b000};
   assign start    = acc_valid & ~flush;
   assign timeout  = (cnt == CNT_LAST);
   assign finish   = bus.ack | timeout;
   assign squash_c = squash | flush;
   assign acc_err  = (state == DONE) & (err_cause != 2'b00);

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      mem_stall = 1'b0;
      unique case (state)
         IDLE: begin
            mem_stall = start;
            if (start) state_n = misal ? DONE : REQ;
         end
         REQ: begin
            mem_stall = 1'b1;
            if (finish) state_n = squash_c ? IDLE : DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         bus.req   <= 1'b0;
         bus.we    <= 1'b0;
         bus.addr  <= 32'h0;
         bus.wea   <= 4'b0000;
         bus.wdata <= 32'h0;
         Data_in   <= 32'h0;
         cnt       <= '0;
         squash    <= 1'b0;
         err_cause <= 2'b00;
      end else begin
         unique case (state)
            IDLE: begin
               if (start && misal) begin
                  err_cause <= 2'b01;
               end else if (start) begin
                  bus.req   <= 1'b1;
                  bus.we    <= acc_we;
                  bus.addr  <= {acc_addr[31:2], 2'b00};
                  bus.wea   <= wea_c;
                  bus.wdata <= wdata_c;
                  cnt       <= '0;
                  squash    <= 1'b0;
                  err_cause <= 2'b00;
               end
            end
            REQ: begin
               cnt <= cnt + 1'b1;
               if (flush) squash <= 1'b1;
               if (finish) begin
                  bus.req <= 1'b0;
                  bus.we  <= 1'b0;
                  bus.wea <= 4'b0000;
               end
               // A squashed transfer still runs to completion but leaves
               // no architectural trace.
               if (finish && !squash_c) begin
                  if (bus.ack) begin
                     if (!bus.we) Data_in <= bus.rdata;
                  end else begin
                     Data_in   <= 32'h0;
                     err_cause <= 2'b10;
                  end
               end
            end
            DONE: begin
               err_cause <= 2'b00;
            end
            default: ;
         endcase
      end
   end

endmodule
